// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined Hack ALU, parametrised by WIDTH.
//
// Purpose:
//   Computes the Hack zx/nx/zy/ny/f/no function on WIDTH-bit operands.
//   Stage 1 registers the preset operands (x2, y2) and the f/no bits.
//   Stage 2 registers the result and its zr/ng flags. Both ends use
//   valid/ready handshakes with full backpressure. With no stall the
//   latency is 2 cycles and the throughput is 1 result per cycle.
//
// Build option:
//   ALU_CARRY_EN - adds the carry/ovf outputs. These flags describe the
//                  x2+y2 sum before the no inversion, and both are 0 when f=0.
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      request present on x/y/ctrl
//   in_ready   out  1      request accepted this cycle (combinational)
//   x, y       in   WIDTH  operands
//   ctrl       in   6      {zx,nx,zy,ny,f,no}
//   out_valid  out  1      result present on out/zr/ng
//   out_ready  in   1      consumer takes the result this cycle
//   out        out  WIDTH  result
//   zr         out  1      out == 0
//   ng         out  1      out[WIDTH-1]
//   carry      out  1      (ALU_CARRY_EN) unsigned carry of x2+y2
//   ovf        out  1      (ALU_CARRY_EN) signed overflow of x2+y2

module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_CARRY_EN
    ,
    output logic             carry,
    output logic             ovf
`endif
);

    logic             s1_v;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_f;
    logic             s1_no;
    logic             s2_v;

    logic             accept;
    logic             s2_adv;

    logic [WIDTH-1:0] x_z;
    logic [WIDTH-1:0] y_z;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y2;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] res;

    // Handshake control.
    assign s2_adv    = s1_v && (!s2_v || out_ready);
    assign in_ready  = !reset && (!s1_v || s2_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;

    // Operand presets, formed from the live inputs and captured only on accept.
    always_comb begin
        x_z = ctrl[5] ? '0 : x;
        x2  = ctrl[4] ? ~x_z : x_z;
        y_z = ctrl[3] ? '0 : y;
        y2  = ctrl[2] ? ~y_z : y_z;
    end

`ifdef ALU_CARRY_EN
    // The adder is widened by one bit so the carry out can be kept.
    logic [WIDTH:0] sum_ext;
    logic           carry_c;
    logic           ovf_c;

    always_comb begin
        sum_ext = {1'b0, s1_x} + {1'b0, s1_y};
        sum     = sum_ext[WIDTH-1:0];
        carry_c = s1_f & sum_ext[WIDTH];
        // Signed overflow: the operands agree in sign and the sum does not.
        ovf_c   = s1_f & (s1_x[WIDTH-1] == s1_y[WIDTH-1])
                       & (sum_ext[WIDTH-1] != s1_x[WIDTH-1]);
    end
`else
    assign sum = s1_x + s1_y;
`endif

    always_comb begin
        o   = s1_f ? sum : (s1_x & s1_y);
        res = s1_no ? ~o : o;
    end

    // Stage 1
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v  <= 1'b0;
            s1_x  <= '0;
            s1_y  <= '0;
            s1_f  <= 1'b0;
            s1_no <= 1'b0;
        end else if (accept) begin
            s1_v  <= 1'b1;
            s1_x  <= x2;
            s1_y  <= y2;
            s1_f  <= ctrl[1];
            s1_no <= ctrl[0];
        end else if (s2_adv) begin
            s1_v  <= 1'b0;
        end
    end

    // Stage 2: data registers change only when stage 1 moves in, so the
    // outputs stay bit-stable through a stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_v <= 1'b0;
            out  <= '0;
            zr   <= 1'b0;
            ng   <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= 1'b1;
            out  <= res;
            zr   <= ~|res;
            ng   <= res[WIDTH-1];
        end else if (out_ready) begin
            s2_v <= 1'b0;
        end
    end

`ifdef ALU_CARRY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (s2_adv) begin
            carry <= carry_c;
            ovf   <= ovf_c;
        end
    end
`endif

endmodule
